// File: rtl/ps2_scancode_rx_if.sv
// Consumer-side bus of the PS/2 scancode receiver: head-of-FIFO view,
// pop strobe and the one-cycle error pulses.
// "release" is a reserved word, so the release flag is carried as is_release.
interface ps2_scancode_rx_if;
  logic       rd_en;
  logic       valid;
  logic [7:0] code;
  logic       extended;
  logic       is_release;
  logic       parity_err;
  logic       timeout_err;
  logic       overflow;

  modport master (
    input  rd_en,
    output valid, code, extended, is_release, parity_err, timeout_err, overflow
  );

  modport slave (
    output rd_en,
    input  valid, code, extended, is_release, parity_err, timeout_err, overflow
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the PS/2 pins,
// deframes 11-bit device->host frames with odd parity, and queues scancodes
// in a small show-ahead FIFO.
// Optional feature macro: PS2_PREFIX_DECODE_EN -- when defined, E0/F0 prefix
// bytes are folded into extended/release flags instead of being queued raw.
module ps2_scancode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 32000,
  parameter int FIFO_AW     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_scancode_rx_if.master bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FCW   = $clog2(FILTER_LEN) + 1;
  localparam int TCW   = $clog2(TIMEOUT_CYC + 1);
  localparam int CW    = FIFO_AW + 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Input synchronisers and glitch filter
  logic           clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic           dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic           filt_clk_q, filt_clk_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall;

  // Deframer
  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           byte_vld_q, byte_vld_d;
  logic [7:0]     byte_q, byte_d;
  logic           perr_q, perr_d;
  logic           tmo_err_q, tmo_err_d;

  // Prefix handling and FIFO
`ifdef PS2_PREFIX_DECODE_EN
  logic           ext_q, ext_d, rel_q, rel_d;
`endif
  logic           push, pop, full, wr_en;
  logic [9:0]     push_data;
  logic [9:0]     fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;

  // Synchronise both pins; filtered clk only changes after FILTER_LEN stable samples
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = clk_s2_q;
        fall       = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end
    end
  end

  // Frame FSM: advances on filtered falls, aborts to IDLE on a stalled frame
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    perr_d     = 1'b0;
    tmo_err_d  = 1'b0;
    tmo_d      = (state_q == S_IDLE || fall) ? '0 : tmo_q + TCW'(1);
    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        default: begin
          if (dat_s2_q && (^{shift_q, par_q})) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            perr_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      state_d   = S_IDLE;
      shift_d   = '0;
      tmo_d     = '0;
      tmo_err_d = 1'b1;
    end
  end

  // Byte handling (prefix folding) and FIFO pointer/count bookkeeping
  always_comb begin
`ifdef PS2_PREFIX_DECODE_EN
    ext_d     = ext_q;
    rel_d     = rel_q;
    push      = 1'b0;
    push_data = {ext_q, rel_q, byte_q};
    if (byte_vld_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        rel_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
`else
    push      = byte_vld_q;
    push_data = {2'b00, byte_q};
`endif
    pop      = bus.rd_en && (count_q != '0);
    full     = (count_q == FULL_CNT);
    wr_en    = push && (!full || pop);
    ovf_d    = push && full && !pop;
    wr_ptr_d = wr_ptr_q + FIFO_AW'(wr_en);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
    count_d  = count_q + CW'(wr_en) - CW'(pop);
  end

  // State registers; bus idles high so synchronisers and filter reset to 1
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      perr_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      perr_q     <= perr_d;
      tmo_err_q  <= tmo_err_d;
`ifdef PS2_PREFIX_DECODE_EN
      ext_q      <= ext_d;
      rel_q      <= rel_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by valid
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= push_data;
  end

  assign bus.valid       = (count_q != '0);
  assign bus.code        = bus.valid ? fifo_mem[rd_ptr_q][7:0] : 8'h00;
  assign bus.extended    = bus.valid & fifo_mem[rd_ptr_q][9];
  assign bus.is_release  = bus.valid & fifo_mem[rd_ptr_q][8];
  assign bus.parity_err  = perr_q;
  assign bus.timeout_err = tmo_err_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: table of single frames, directed corner
// sequences, then random frames against a queue-based reference model.
module tb_ps2_scancode_rx;
  localparam int H     = 20;   // half bit period in clk cycles
  localparam int TMO   = 300;
  localparam int FL    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_scancode_rx_if bus_if();

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int perr_seen = 0, tmo_seen = 0, ovf_seen = 0;

  always @(negedge clk) begin
    if (bus_if.parity_err)  perr_seen <= perr_seen + 1;
    if (bus_if.timeout_err) tmo_seen  <= tmo_seen + 1;
    if (bus_if.overflow)    ovf_seen  <= ovf_seen + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // reference model: expected FIFO contents {ext,rel,code} and prefix state
  logic [9:0] exp_q[$];
  bit m_ext = 0, m_rel = 0;

  typedef struct {
    logic [7:0] b;
    bit bad_par;
    bit bad_stop;
    bit exp_valid;
    logic [7:0] exp_code;
    bit exp_perr;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      cycles(6);
      if (glitch) begin
        ps2_clk = 1'b0;
        cycles(3);
        ps2_clk = 1'b1;
        cycles(H - 9);
      end else begin
        cycles(H - 6);
      end
      ps2_clk = 1'b0;
      cycles(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cycles(H);
  endtask

  task automatic model_byte(input logic [7:0] b, output bit ovf);
    logic [9:0] e;
    bit do_push;
    ovf = 0;
    do_push = 1;
`ifdef PS2_PREFIX_DECODE_EN
    if (b == 8'hE0) begin
      m_ext = 1; do_push = 0;
    end else if (b == 8'hF0) begin
      m_rel = 1; do_push = 0;
    end
    e = {m_ext, m_rel, b};
`else
    e = {2'b00, b};
`endif
    if (do_push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(e);
      else ovf = 1;
      m_ext = 0;
      m_rel = 0;
    end
  endtask

  task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    int p0, o0, t0;
    bit ovf, good;
    p0 = perr_seen; o0 = ovf_seen; t0 = tmo_seen;
    good = !bad_par && !bad_stop;
    ovf = 0;
    send_bits(mk_frame(b, bad_par, bad_stop), 11, glitch);
    cycles(H);
    if (good) model_byte(b, ovf);
    $display("frame %02h bad_par=%0d bad_stop=%0d glitch=%0d queued=%0d", b, bad_par, bad_stop, glitch, exp_q.size());
    @(negedge clk);
    chk("frame_parity_err", perr_seen - p0, good ? 0 : 1);
    chk("frame_overflow", ovf_seen - o0, ovf ? 1 : 0);
    chk("frame_timeout_err", tmo_seen - t0, 0);
    chk("frame_valid", bus_if.valid, exp_q.size() != 0);
  endtask

  task automatic pop_chk(input string nm, input logic [9:0] e);
    @(negedge clk);
    $display("pop %s code=%02h ext=%0d rel=%0d exp=%03h", nm, bus_if.code, bus_if.extended, bus_if.is_release, e);
    chk({nm, "_valid"}, bus_if.valid, 1);
    chk({nm, "_code"}, bus_if.code, e[7:0]);
    chk({nm, "_ext"}, bus_if.extended, e[9]);
    chk({nm, "_rel"}, bus_if.is_release, e[8]);
    bus_if.rd_en = 1'b1;
    @(posedge clk);
    #1;
    bus_if.rd_en = 1'b0;
  endtask

  task automatic drain(input string nm);
    while (exp_q.size() > 0) pop_chk(nm, exp_q.pop_front());
    @(negedge clk);
    chk({nm, "_empty"}, bus_if.valid, 0);
  endtask

  initial begin
    int p0, t0, o0;
    bit ovf;
    bus_if.rd_en = 1'b0;

    tbl[0] = '{8'h1C, 0, 0, 1, 8'h1C, 0};
    tbl[1] = '{8'h1C, 1, 0, 0, 8'h00, 1};
    tbl[2] = '{8'h29, 0, 0, 1, 8'h29, 0};
    tbl[3] = '{8'h5A, 0, 1, 0, 8'h00, 1};
    tbl[4] = '{8'h00, 0, 0, 1, 8'h00, 0};
    tbl[5] = '{8'hFF, 0, 0, 1, 8'hFF, 0};

    cycles(4);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus_if.valid, 0);
    chk("rst_code", bus_if.code, 0);
    chk("rst_ext", bus_if.extended, 0);
    chk("rst_rel", bus_if.is_release, 0);
    chk("rst_parity_err", bus_if.parity_err, 0);
    chk("rst_timeout_err", bus_if.timeout_err, 0);
    chk("rst_overflow", bus_if.overflow, 0);
    cycles(2);

    // table-driven single frames, each drained before the next
    for (int i = 0; i < 6; i++) begin
      p0 = perr_seen;
      send_bits(mk_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop), 11, 0);
      cycles(H);
      $display("vec %0d byte=%02h bad_par=%0d bad_stop=%0d", i, tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop);
      @(negedge clk);
      chk("vec_parity_err", perr_seen - p0, tbl[i].exp_perr);
      chk("vec_valid", bus_if.valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        pop_chk("vec", {2'b00, tbl[i].exp_code});
        @(negedge clk);
        chk("vec_empty", bus_if.valid, 0);
      end
    end

    // prefix sequences
    do_frame(8'hF0, 0, 0, 0);
    do_frame(8'h1C, 0, 0, 0);
    drain("f0_1c");
    do_frame(8'hE0, 0, 0, 0);
    do_frame(8'hF0, 0, 0, 0);
    do_frame(8'h75, 0, 0, 0);
    drain("e0_f0_75");

    // timeout mid-frame; a pending E0 flag survives the abort
    do_frame(8'hE0, 0, 0, 0);
    p0 = perr_seen; t0 = tmo_seen;
    send_bits(mk_frame(8'h33, 0, 0), 5, 0);
    cycles(TMO + 60);
    $display("timeout partial frame");
    @(negedge clk);
    chk("tmo_pulse", tmo_seen - t0, 1);
    chk("tmo_no_perr", perr_seen - p0, 0);
    chk("tmo_valid", bus_if.valid, exp_q.size() != 0);
    do_frame(8'h5A, 0, 0, 0);
    drain("after_tmo");

    // overflow with depth 4
    do_frame(8'h16, 0, 0, 0);
    do_frame(8'h1E, 0, 0, 0);
    do_frame(8'h26, 0, 0, 0);
    do_frame(8'h25, 0, 0, 0);
    do_frame(8'h2E, 0, 0, 0);
    drain("overflow");

    // pop while empty is ignored
    bus_if.rd_en = 1'b1;
    cycles(3);
    bus_if.rd_en = 1'b0;
    @(negedge clk);
    chk("pop_empty_valid", bus_if.valid, 0);
    do_frame(8'h1C, 0, 0, 0);
    drain("after_pop_empty");

    // short low glitches between bits
    do_frame(8'h1C, 0, 0, 1);
    drain("glitch");

    // reset mid-frame with an entry queued
    do_frame(8'h29, 0, 0, 0);
    send_bits(mk_frame(8'h44, 0, 0), 6, 0);
    p0 = perr_seen; t0 = tmo_seen; o0 = ovf_seen;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    exp_q.delete();
    m_ext = 0; m_rel = 0;
    cycles(TMO + 20);
    $display("reset mid-frame");
    @(negedge clk);
    chk("midrst_valid", bus_if.valid, 0);
    chk("midrst_errs", (perr_seen - p0) + (tmo_seen - t0) + (ovf_seen - o0), 0);
    do_frame(8'h5A, 0, 0, 0);
    drain("after_midrst");

    // random frames against the model
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [7:0] b;
      bit bp, bs;
      r = $urandom_range(0, 9);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 14) == 0);
      do_frame(b, bp, bs, $urandom_range(0, 3) == 0);
      r = $urandom_range(0, 3);
      if (r == 0) drain("rnd_drain");
      else if (r == 1 && exp_q.size() > 0) pop_chk("rnd_pop", exp_q.pop_front());
    end
    drain("final");
    ovf = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
